// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, sigma functions and round constants used by the
// message schedule and the round stage.
package sha256_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic {
        SCHED_IDLE = 1'b0,
        SCHED_RUN  = 1'b1
    } sched_state_e;

    localparam int NUM_ROUNDS_DEF = 64;

    // Message-schedule sigmas (lower case s0/s1).
    function automatic word_t sig0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic word_t sig1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // Compression-round Sigmas (upper case).
    function automatic word_t bsig0(input word_t x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic word_t bsig1(input word_t x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    localparam word_t K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

endpackage

// File: rtl/sha256_w_next.sv
// Next schedule word from the 16-word window: s1(w14) + w9 + s0(w1) + w0.
module sha256_w_next
    import sha256_pkg::*;
(
    input  word_t w0,
    input  word_t w1,
    input  word_t w9,
    input  word_t w14,
    output word_t w_new
);

    assign w_new = sig1(w14) + w9 + sig0(w1) + w0;

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: one 512-bit block in, W[0..NUM_ROUNDS-1] out over a
// valid/ready stream. Define SCHED_BACK2BACK_EN to accept the next block on the last word.
module sha256_msg_schedule
    import sha256_pkg::*;
#(
    parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
    parameter int IDX_W      = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             blk_valid,
    output logic             blk_ready,
    input  logic [511:0]     blk_data,
    output logic             w_valid,
    input  logic             w_ready,
    output logic [31:0]      w_data,
    output logic [IDX_W-1:0] w_idx,
    output logic             w_last
);

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_ROUNDS - 1);
    localparam logic [IDX_W-1:0] PRELAST_IDX = IDX_W'(NUM_ROUNDS - 2);

    sched_state_e     state_q, state_d;
    word_t            win_q [16];
    word_t            win_d [16];
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             w_valid_q, w_valid_d;
    logic             w_last_q, w_last_d;
    logic             blk_ready_q, blk_ready_d;
    word_t            w_new;
    logic             hs, last_hs, reload;

    sha256_w_next u_w_next (
        .w0   (win_q[0]),
        .w1   (win_q[1]),
        .w9   (win_q[9]),
        .w14  (win_q[14]),
        .w_new(w_new)
    );

    assign hs      = w_valid_q && w_ready;
    assign last_hs = hs && (idx_q == LAST_IDX);

`ifdef SCHED_BACK2BACK_EN
    // The only combinational ready path: the next block may land on the last word.
    assign reload    = blk_valid;
    assign blk_ready = blk_ready_q || (w_valid_q && (idx_q == LAST_IDX) && w_ready);
`else
    assign reload    = 1'b0;
    assign blk_ready = blk_ready_q;
`endif

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        idx_d       = idx_q;
        w_valid_d   = w_valid_q;
        w_last_d    = w_last_q;
        blk_ready_d = blk_ready_q;
        case (state_q)
            SCHED_IDLE: begin
                if (blk_valid) begin
                    for (int i = 0; i < 16; i++) win_d[i] = blk_data[511-32*i -: 32];
                    idx_d       = '0;
                    state_d     = SCHED_RUN;
                    w_valid_d   = 1'b1;
                    w_last_d    = 1'b0;
                    blk_ready_d = 1'b0;
                end
            end
            default: begin
                if (hs) begin
                    for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
                    win_d[15] = w_new;
                    idx_d     = idx_q + 1'b1;
                    w_last_d  = (idx_q == PRELAST_IDX);
                    if (last_hs) begin
                        idx_d    = '0;
                        w_last_d = 1'b0;
                        if (reload) begin
                            for (int i = 0; i < 16; i++) win_d[i] = blk_data[511-32*i -: 32];
                        end else begin
                            state_d     = SCHED_IDLE;
                            w_valid_d   = 1'b0;
                            blk_ready_d = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SCHED_IDLE;
            for (int i = 0; i < 16; i++) win_q[i] <= '0;
            idx_q       <= '0;
            w_valid_q   <= 1'b0;
            w_last_q    <= 1'b0;
            blk_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            idx_q       <= idx_d;
            w_valid_q   <= w_valid_d;
            w_last_q    <= w_last_d;
            blk_ready_q <= blk_ready_d;
        end
    end

    assign w_valid = w_valid_q;
    assign w_data  = win_q[0];
    assign w_idx   = idx_q;
    assign w_last  = w_last_q;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Randomized self-checking bench for sha256_msg_schedule against a direct
// W[t] recurrence model (no sliding window).
module tb_sha256_msg_schedule;

    localparam int NR    = 64;
    localparam int IDX_W = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             blk_valid = 1'b0;
    logic             blk_ready;
    logic [511:0]     blk_data = '0;
    logic             w_valid;
    logic             w_ready = 1'b0;
    logic [31:0]      w_data;
    logic [IDX_W-1:0] w_idx;
    logic             w_last;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] blk_m [16];
    logic [31:0] nxt_m [16];
    logic [31:0] exp_w [NR];
    logic [31:0] got_w [NR];

    sha256_msg_schedule #(.NUM_ROUNDS(NR), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .w_idx(w_idx), .w_last(w_last)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook recurrence over the full 64-entry array.
    task automatic compute_exp();
        logic [31:0] w [64];
        logic [31:0] a, b;
        for (int t = 0; t < 16; t++) w[t] = blk_m[t];
        for (int t = 16; t < 64; t++) begin
            a = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            b = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = b + w[t-7] + a + w[t-16];
        end
        for (int t = 0; t < NR; t++) exp_w[t] = w[t];
    endtask

    function automatic logic [511:0] pack_m(input logic [31:0] m [16]);
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[511-32*i -: 32] = m[i];
        return d;
    endfunction

    task automatic start_block();
        int waited;
        @(negedge clk);
        blk_data  = pack_m(blk_m);
        blk_valid = 1'b1;
        waited = 0;
        while (!blk_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (waited >= 200) begin
            n_fail++;
            $display("FAIL blk_accept_timeout: blk_ready=%0b required 1", blk_ready);
        end
        @(negedge clk);
        blk_valid = 1'b0;
    endtask

    // Consume n words; mode 1 presents nxt_m on the last word, mode 2 drops blk_valid there.
    task automatic run_words(input int n, input bit rnd, input int mode);
        int cnt, cyc, hold;
        bit r, prev_v, prev_r, stop;
        logic [31:0] prev_d;
        logic [IDX_W-1:0] prev_i;
        cnt = 0; cyc = 0; hold = 0; r = 1'b1; prev_v = 1'b0; prev_r = 1'b1; stop = 1'b0;
        prev_d = '0; prev_i = '0;
        while (cnt < n && cyc < 4000 && !stop) begin
            if (rnd) begin
                if (hold == 0) begin
                    r = 1'($urandom_range(0, 1));
                    hold = 5;
                end
                hold--;
            end else begin
                r = 1'b1;
            end
            w_ready = r;
            n_checks++;
            if (w_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL w_valid_gap: w_valid=%0b required 1 at word %0d", w_valid, cnt);
                stop = 1'b1;
            end else begin
                if (prev_v && !prev_r) begin
                    n_checks++;
                    if (w_data !== prev_d || w_idx !== prev_i) begin
                        n_fail++;
                        $display("FAIL stall_hold: data=%h idx=%0d required data=%h idx=%0d",
                                 w_data, w_idx, prev_d, prev_i);
                    end
                end
                n_checks++;
                if (w_idx !== cnt[IDX_W-1:0]) begin
                    n_fail++;
                    $display("FAIL w_idx: got %0d required %0d", w_idx, cnt);
                end
                n_checks++;
                if (w_data !== exp_w[cnt]) begin
                    n_fail++;
                    $display("FAIL w_data[%0d]: got %h required %h", cnt, w_data, exp_w[cnt]);
                end
                n_checks++;
                if (w_last !== (cnt == NR - 1)) begin
                    n_fail++;
                    $display("FAIL w_last[%0d]: got %0b required %0b", cnt, w_last, cnt == NR - 1);
                end
`ifndef SCHED_BACK2BACK_EN
                n_checks++;
                if (blk_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL blk_ready_run[%0d]: got %0b required 0", cnt, blk_ready);
                end
`endif
                if (cnt == n - 1 && mode == 1) begin
                    blk_data  = pack_m(nxt_m);
                    blk_valid = 1'b1;
                end
                if (cnt == n - 1 && mode == 2) blk_valid = 1'b0;
                if (r) begin
                    got_w[cnt] = w_data;
                    cnt++;
                end
            end
            prev_v = w_valid; prev_r = r; prev_d = w_data; prev_i = w_idx;
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cnt < n) begin
            n_fail++;
            $display("FAIL word_count: got %0d words required %0d", cnt, n);
        end
    endtask

    task automatic check_idle_after(input string tag);
        n_checks++;
        if (w_valid !== 1'b0 || blk_ready !== 1'b1 || w_last !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle: w_valid=%0b blk_ready=%0b w_last=%0b required 0/1/0",
                     tag, w_valid, blk_ready, w_last);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (w_valid !== 1'b0 || blk_ready !== 1'b1 || w_last !== 1'b0 ||
            w_idx !== '0 || w_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: v=%0b rdy=%0b last=%0b idx=%0d data=%h required 0/1/0/0/0",
                     w_valid, blk_ready, w_last, w_idx, w_data);
        end
        rst = 1'b0;
    endtask

    task automatic load_abc();
        for (int i = 0; i < 16; i++) blk_m[i] = 32'h0;
        blk_m[0]  = 32'h61626380;
        blk_m[15] = 32'h00000018;
        compute_exp();
    endtask

    task automatic test_abc();
        logic [31:0] known [6];
        int          kidx  [6];
        known = '{32'h61626380, 32'h00000018, 32'h61626380,
                  32'h000F0000, 32'h7DA86405, 32'h600003C6};
        kidx  = '{0, 15, 16, 17, 18, 19};
        load_abc();
        start_block();
        run_words(NR, 1'b0, 0);
        check_idle_after("abc");
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (got_w[kidx[k]] !== known[k]) begin
                n_fail++;
                $display("FAIL abc_known_W[%0d]: got %h required %h", kidx[k], got_w[kidx[k]], known[k]);
            end
        end
    endtask

    task automatic test_stall();
        load_abc();
        start_block();
        run_words(NR, 1'b1, 0);
        check_idle_after("stall");
        w_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 16; i++) blk_m[i] = $urandom;
        compute_exp();
        start_block();
        run_words(20, 1'b0, 0);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (w_valid !== 1'b0 || blk_ready !== 1'b1 || w_idx !== '0 || w_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid: v=%0b rdy=%0b idx=%0d data=%h required 0/1/0/0",
                     w_valid, blk_ready, w_idx, w_data);
        end
        rst = 1'b0;
        for (int i = 0; i < 16; i++) blk_m[i] = $urandom;
        compute_exp();
        start_block();
        run_words(NR, 1'b0, 0);
        check_idle_after("restart");
    endtask

    task automatic test_ignore_blk();
        logic [31:0] other [16];
        for (int i = 0; i < 16; i++) blk_m[i] = $urandom;
        for (int i = 0; i < 16; i++) other[i] = ~blk_m[i];
        compute_exp();
        start_block();
        blk_data  = pack_m(other);
        blk_valid = 1'b1;
        run_words(NR, 1'b1, 2);
        check_idle_after("ignore");
        w_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) blk_m[i] = $urandom;
        for (int i = 0; i < 16; i++) nxt_m[i] = $urandom;
        compute_exp();
        start_block();
        run_words(NR, 1'b0, 1);
`ifndef SCHED_BACK2BACK_EN
        n_checks++;
        if (w_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_bubble: w_valid=%0b required 0", w_valid);
        end
        @(negedge clk);
`endif
        n_checks++;
        if (w_valid !== 1'b1 || w_idx !== '0 || w_data !== nxt_m[0]) begin
            n_fail++;
            $display("FAIL b2b_first: v=%0b idx=%0d data=%h required 1/0/%h",
                     w_valid, w_idx, w_data, nxt_m[0]);
        end
        blk_valid = 1'b0;
        blk_m = nxt_m;
        compute_exp();
        run_words(NR, 1'b0, 2);
        check_idle_after("b2b");
    endtask

    task automatic test_all_ones();
        for (int i = 0; i < 16; i++) blk_m[i] = 32'hFFFFFFFF;
        compute_exp();
        start_block();
        run_words(NR, 1'b0, 0);
        check_idle_after("ones");
    endtask

    task automatic test_random_blocks();
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 16; i++) blk_m[i] = $urandom;
            compute_exp();
            start_block();
            run_words(NR, 1'b1, 0);
            check_idle_after("rand");
            w_ready = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_stall();
        test_reset_mid();
        test_ignore_blk();
        test_back_to_back();
        test_all_ones();
        test_random_blocks();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
